bw_clk_fdbk_mon: RTL and testbench
==================================

Name: bw_clk_fdbk_mon

Overview:
Parametrised multi-channel clock-feedback monitor, the successor to the fixed single-path feedback chain. It samples NCH feedback clocks returned from the global/cluster clock tree into the rclk domain. It counts rising edges per channel over a programmable window and checks each count against an expected value with tolerance. Results drive clock-tree health status and sticky fault flags for the test/CSR logic.

Parameters:
NCH, 4, number of feedback channels monitored
CNT_W, 12, per-channel edge-counter width
WIN_W, 16, window-length counter width
SYNC_STG, 2, synchronizer flops per channel (min 2)

Ports:
rclk  in  1  monitor clock; all logic on rising edge
rst_l  in  1  synchronous active-low reset
fdbk_in  in  NCH  feedback clocks; asynchronous to rclk; frequency < rclk/2
mon_en  in  1  level; 1 = run windows back-to-back, 0 = stop/abort
win_len  in  WIN_W  window length in rclk cycles; sampled in ARM; 0 treated as 1
exp_cnt  in  CNT_W  expected edges per window; sampled in ARM
tol  in  CNT_W  allowed |count - exp_cnt|; sampled in ARM
fault_clr  in  1  clears all ch_fault bits
busy  out  1  state != IDLE
meas_vld  out  1  one-cycle pulse: results updated
meas_cnt  out  NCH*CNT_W  last window counts, channel i at [i*CNT_W +: CNT_W]
ch_ok  out  NCH  last window per-channel pass
ch_fault  out  NCH  sticky per-channel fail

Behaviour:
- Reset (rst_l=0 at rclk edge): state=IDLE; synchronizers, edge-history, counters, meas_cnt, ch_ok, ch_fault, meas_vld, busy all 0.
- Per channel: SYNC_STG-flop synchronizer, then one history flop; edge = sync & ~hist. Runs every cycle in all states. Because history resets to 0, no false edge after reset or ARM.
- FSM states: IDLE, ARM, COUNT, EVAL.
  - IDLE: mon_en=1 -> ARM.
  - ARM (1 cycle): clear edge counters; latch max(win_len,1) into the window counter; latch exp_cnt and tol. -> COUNT.
  - COUNT: each cycle, counter[i]++ on edge[i], saturating at 2^CNT_W-1; window counter decrements. The cycle with window counter == 1 is the last COUNT cycle -> EVAL.
  - EVAL (1 cycle): diff = |cnt - exp| computed in CNT_W+1 bits; ok[i] = diff <= tol. At end of EVAL, register meas_cnt and ch_ok, and set meas_vld=1 for the next cycle. Next state = ARM if mon_en=1, else IDLE.
- mon_en=0 during ARM or COUNT: next state IDLE. Counters cleared. No meas_vld. meas_cnt, ch_ok and ch_fault keep prior values.
- mon_en=0 during EVAL: the result still completes.
- Latency: mon_en first seen high in IDLE at cycle 0 -> ARM cycle 1, COUNT cycles 2..N+1, EVAL cycle N+2, meas_vld=1 at cycle N+3. In continuous mode, cycle N+3 is also the next ARM, so results come every N+2 cycles.
- ch_fault[i] is set in the meas_vld cycle when ch_ok[i]=0. fault_clr clears all bits. If a set and fault_clr occur in the same cycle, the set wins for that bit.
- Edges arrive SYNC_STG+1 cycles late; only edges detected during COUNT are counted. Count accuracy is ±1 per window.

Optional Feature:
BW_CLK_FDBK_MON_HIST_EN:
- Defined: adds outputs cnt_min and cnt_max, each NCH*CNT_W. These hold the per-channel min and max of meas_cnt across windows.
- At each meas_vld, each channel's min/max updates against the new count.
- fault_clr or reset loads min=all-ones and max=0. On the first window after that, both take the measured value.
- Not defined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset check: drive random inputs with rst_l=0 for 5 cycles -> all outputs 0, busy=0. Release with mon_en=0 -> remain 0.
- Nominal count: fdbk_in[0] period 8 rclk, win_len=80, exp_cnt=10, tol=1, mon_en pulsed 1 cycle -> meas_vld exactly at cycle 83. meas_cnt[0] in {9,10,11}, ch_ok[0]=1, ch_fault[0]=0.
- Stuck channel: fdbk_in[2]=0, exp_cnt=10, tol=1 -> meas_cnt[2]=0, ch_ok[2]=0, ch_fault[2]=1. The bit stays 1 through later good windows until fault_clr. fault_clr in the same cycle as a new failing meas_vld -> bit remains 1.
- Saturation and window bounds:
  - fdbk_in[1] period 4, win_len=65535 -> meas_cnt[1]=4095.
  - win_len=0 -> window of 1 cycle, meas_vld 3 cycles after ARM entry.
- Abort and continuous mode:
  - mon_en held 1, win_len=20 -> meas_vld every 22 cycles.
  - Drop mon_en during COUNT -> IDLE next cycle, no meas_vld, meas_cnt unchanged.
- HIST_EN (macro defined): window counts 10, 12, 9 on ch0 -> cnt_min[0]=9, cnt_max[0]=12. After fault_clr, the next window of count 11 -> min=max=11.

Source files
------------

// File: rtl/bw_clk_fdbk_mon.sv
// Multi-channel clock-feedback monitor: counts feedback-clock rising edges per window and grades them.
// Optional macro BW_CLK_FDBK_MON_HIST_EN adds per-channel min/max count history outputs.
module bw_clk_fdbk_mon #(
    parameter int NCH      = 4,
    parameter int CNT_W    = 12,
    parameter int WIN_W    = 16,
    parameter int SYNC_STG = 2
) (
    input  logic                 rclk,
    input  logic                 rst_l,
    input  logic [NCH-1:0]       fdbk_in,
    input  logic                 mon_en,
    input  logic [WIN_W-1:0]     win_len,
    input  logic [CNT_W-1:0]     exp_cnt,
    input  logic [CNT_W-1:0]     tol,
    input  logic                 fault_clr,
    output logic                 busy,
    output logic                 meas_vld,
    output logic [NCH*CNT_W-1:0] meas_cnt,
    output logic [NCH-1:0]       ch_ok,
    output logic [NCH-1:0]       ch_fault
`ifdef BW_CLK_FDBK_MON_HIST_EN
    ,
    output logic [NCH*CNT_W-1:0] cnt_min,
    output logic [NCH*CNT_W-1:0] cnt_max
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_COUNT = 2'd2,
        ST_EVAL  = 2'd3
    } state_t;

    state_t           state_reg, state_next;
    logic [WIN_W-1:0] win_cnt_reg;
    logic [CNT_W-1:0] exp_reg;
    logic [CNT_W-1:0] tol_reg;
    logic             meas_vld_reg;

    always_ff @(posedge rclk) begin
        if (!rst_l) begin
            state_reg    <= ST_IDLE;
            win_cnt_reg  <= '0;
            exp_reg      <= '0;
            tol_reg      <= '0;
            meas_vld_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            meas_vld_reg <= (state_reg == ST_EVAL);
            if (state_reg == ST_ARM) begin
                // A zero-length window still needs one COUNT cycle to terminate.
                win_cnt_reg <= (win_len == '0) ? WIN_W'(1) : win_len;
                exp_reg     <= exp_cnt;
                tol_reg     <= tol;
            end else if (state_reg == ST_COUNT) begin
                win_cnt_reg <= win_cnt_reg - WIN_W'(1);
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (mon_en) state_next = ST_ARM;
            ST_ARM:   state_next = mon_en ? ST_COUNT : ST_IDLE;
            ST_COUNT: begin
                if (!mon_en)
                    state_next = ST_IDLE;
                else if (win_cnt_reg == WIN_W'(1))
                    state_next = ST_EVAL;
            end
            ST_EVAL:  state_next = mon_en ? ST_ARM : ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    assign busy     = (state_reg != ST_IDLE);
    assign meas_vld = meas_vld_reg;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            logic [SYNC_STG-1:0] sync_reg;
            logic                hist_reg;
            logic                rise;
            logic [CNT_W-1:0]    cnt_reg;
            logic [CNT_W-1:0]    meas_reg;
            logic                ok_reg;
            logic                fault_reg;
            logic [CNT_W:0]      diff;
            logic                pass;

            assign rise = sync_reg[SYNC_STG-1] & ~hist_reg;

            always_ff @(posedge rclk) begin
                if (!rst_l) begin
                    sync_reg <= '0;
                    hist_reg <= 1'b0;
                end else begin
                    sync_reg <= {sync_reg[SYNC_STG-2:0], fdbk_in[gi]};
                    hist_reg <= sync_reg[SYNC_STG-1];
                end
            end

            // Counter holds through EVAL; any other non-counting cycle clears it.
            always_ff @(posedge rclk) begin
                if (!rst_l) begin
                    cnt_reg <= '0;
                end else if (state_reg == ST_COUNT && mon_en) begin
                    if (rise && cnt_reg != '1)
                        cnt_reg <= cnt_reg + CNT_W'(1);
                end else if (state_reg != ST_EVAL) begin
                    cnt_reg <= '0;
                end
            end

            assign diff = (cnt_reg >= exp_reg) ? ({1'b0, cnt_reg} - {1'b0, exp_reg})
                                               : ({1'b0, exp_reg} - {1'b0, cnt_reg});
            assign pass = (diff <= {1'b0, tol_reg});

            always_ff @(posedge rclk) begin
                if (!rst_l) begin
                    meas_reg  <= '0;
                    ok_reg    <= 1'b0;
                    fault_reg <= 1'b0;
                end else begin
                    if (state_reg == ST_EVAL) begin
                        meas_reg <= cnt_reg;
                        ok_reg   <= pass;
                    end
                    // A new failure outranks a simultaneous clear.
                    fault_reg <= (fault_reg & ~fault_clr) | (meas_vld_reg & ~ok_reg);
                end
            end

            assign meas_cnt[gi*CNT_W +: CNT_W] = meas_reg;
            assign ch_ok[gi]                   = ok_reg;
            assign ch_fault[gi]                = fault_reg;

`ifdef BW_CLK_FDBK_MON_HIST_EN
            logic [CNT_W-1:0] min_reg, max_reg;
            logic [CNT_W-1:0] min_base, max_base;

            assign min_base = fault_clr ? '1 : min_reg;
            assign max_base = fault_clr ? '0 : max_reg;

            always_ff @(posedge rclk) begin
                if (!rst_l) begin
                    min_reg <= '1;
                    max_reg <= '0;
                end else if (state_reg == ST_EVAL) begin
                    min_reg <= (cnt_reg < min_base) ? cnt_reg : min_base;
                    max_reg <= (cnt_reg > max_base) ? cnt_reg : max_base;
                end else begin
                    min_reg <= min_base;
                    max_reg <= max_base;
                end
            end

            assign cnt_min[gi*CNT_W +: CNT_W] = min_reg;
            assign cnt_max[gi*CNT_W +: CNT_W] = max_reg;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_bw_clk_fdbk_mon.sv
// Scoreboard bench for bw_clk_fdbk_mon: feedback clocks come from periodic waveform rules,
// expected window counts are computed arithmetically from those rules.
`timescale 1ns/1ps
module tb_bw_clk_fdbk_mon;
    localparam int NCH   = 4;
    localparam int CNT_W = 12;
    localparam int WIN_W = 16;
    localparam int S     = 2;

    logic                 rclk = 1'b0;
    logic                 rst_l = 1'b0;
    logic [NCH-1:0]       fdbk_in = '0;
    logic                 mon_en = 1'b0;
    logic [WIN_W-1:0]     win_len = '0;
    logic [CNT_W-1:0]     exp_cnt = '0;
    logic [CNT_W-1:0]     tol = '0;
    logic                 fault_clr = 1'b0;
    logic                 busy, meas_vld;
    logic [NCH*CNT_W-1:0] meas_cnt;
    logic [NCH-1:0]       ch_ok, ch_fault;
`ifdef BW_CLK_FDBK_MON_HIST_EN
    logic [NCH*CNT_W-1:0] cnt_min, cnt_max;
`endif

    bw_clk_fdbk_mon #(.NCH(NCH), .CNT_W(CNT_W), .WIN_W(WIN_W), .SYNC_STG(S)) dut (
        .rclk(rclk), .rst_l(rst_l), .fdbk_in(fdbk_in), .mon_en(mon_en),
        .win_len(win_len), .exp_cnt(exp_cnt), .tol(tol), .fault_clr(fault_clr),
        .busy(busy), .meas_vld(meas_vld), .meas_cnt(meas_cnt), .ch_ok(ch_ok),
        .ch_fault(ch_fault)
`ifdef BW_CLK_FDBK_MON_HIST_EN
        , .cnt_min(cnt_min), .cnt_max(cnt_max)
`endif
    );

    always #5 rclk = ~rclk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge rclk) cyc <= cyc + 1;

    // Feedback waveform rules per channel
    int per_a[NCH];
    int ph_a[NCH];
    bit stuck_a[NCH];
    bit rand_fdbk = 1'b1;

    function automatic bit wave(input int ch, input int i);
        if (stuck_a[ch]) return 1'b0;
        return ((i + ph_a[ch]) % per_a[ch]) < (per_a[ch] / 2);
    endfunction

    // A rise driven in interval i is visible to the edge detector in interval i+S.
    function automatic int count_edges(input int ch, input int cs, input int ce);
        int n = 0;
        for (int c = cs; c <= ce; c++)
            if (wave(ch, c - S) && !wave(ch, c - S - 1)) n++;
        return n;
    endfunction

    initial forever begin
        @(posedge rclk);
        #2;
        if (rand_fdbk) fdbk_in = NCH'($urandom);
        else for (int ch = 0; ch < NCH; ch++) fdbk_in[ch] = wave(ch, cyc);
    end

    typedef struct {
        int                   vcyc;
        logic [NCH*CNT_W-1:0] cnt;
        logic [NCH-1:0]       ok;
    } exp_t;
    exp_t sb_q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, req, cyc);
        end
    endtask

    // Monitor / scoreboard
    logic [NCH-1:0]       flt_m = '0;
    logic [NCH*CNT_W-1:0] last_cnt_m = '0;
    logic [NCH-1:0]       last_ok_m = '0;
    logic [NCH*CNT_W-1:0] hmin_m = '1;
    logic [NCH*CNT_W-1:0] hmax_m = '0;
    bit                   hchk = 1'b0;

    initial forever begin
        logic [NCH-1:0] nset;
        exp_t e;
        @(negedge rclk);
        if (!rst_l) begin
            flt_m  = '0;
            hmin_m = '1;
            hmax_m = '0;
            hchk   = 1'b0;
        end else begin
            chk("ch_fault", 64'(ch_fault), 64'(flt_m));
`ifdef BW_CLK_FDBK_MON_HIST_EN
            if (hchk) begin
                chk("cnt_min", 64'(cnt_min), 64'(hmin_m));
                chk("cnt_max", 64'(cnt_max), 64'(hmax_m));
            end
`endif
            hchk = 1'b0;
            if (sb_q.size() > 0 && cyc > sb_q[0].vcyc) begin
                total++;
                bad++;
                $display("FAIL meas_vld_timeout: got none expected at cycle %0d", sb_q[0].vcyc);
                void'(sb_q.pop_front());
            end
            nset = '0;
            if (meas_vld) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL meas_vld_unexpected: got 1 expected 0 at cycle %0d", cyc);
                end else begin
                    e = sb_q.pop_front();
                    chk("meas_vld_cycle", 64'(cyc), 64'(e.vcyc));
                    chk("meas_cnt", 64'(meas_cnt), 64'(e.cnt));
                    chk("ch_ok", 64'(ch_ok), 64'(e.ok));
                    $display("window done cycle=%0d meas_cnt=%h ch_ok=%b", cyc, meas_cnt, ch_ok);
                    last_cnt_m = e.cnt;
                    last_ok_m  = e.ok;
                    nset       = ~e.ok;
                    for (int ch = 0; ch < NCH; ch++) begin
                        if (e.cnt[ch*CNT_W +: CNT_W] < hmin_m[ch*CNT_W +: CNT_W])
                            hmin_m[ch*CNT_W +: CNT_W] = e.cnt[ch*CNT_W +: CNT_W];
                        if (e.cnt[ch*CNT_W +: CNT_W] > hmax_m[ch*CNT_W +: CNT_W])
                            hmax_m[ch*CNT_W +: CNT_W] = e.cnt[ch*CNT_W +: CNT_W];
                    end
                    hchk = 1'b1;
                end
            end
            flt_m = (flt_m & ~{NCH{fault_clr}}) | nset;
            if (fault_clr) begin
                hmin_m = '1;
                hmax_m = '0;
            end
        end
    end

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    // Run nwin back-to-back windows; mon_en drops in the final EVAL cycle.
    task automatic run_win(input int wl, input int ex, input int tl, input int nwin, input bit clr_last);
        int   n, c0, last_eval, last_vld;
        exp_t e;
        win_len = WIN_W'(wl);
        exp_cnt = CNT_W'(ex);
        tol     = CNT_W'(tl);
        repeat (4) tick();
        mon_en = 1'b1;
        c0 = cyc;
        n  = (wl == 0) ? 1 : wl;
        last_eval = 0;
        last_vld  = 0;
        for (int w = 0; w < nwin; w++) begin
            e.vcyc = c0 + n + 3;
            for (int ch = 0; ch < NCH; ch++) begin
                int c = count_edges(ch, c0 + 2, c0 + n + 1);
                int d;
                if (c > 4095) c = 4095;
                d = (c > ex) ? c - ex : ex - c;
                e.cnt[ch*CNT_W +: CNT_W] = CNT_W'(c);
                e.ok[ch] = (d <= tl);
            end
            sb_q.push_back(e);
            last_eval = c0 + n + 2;
            last_vld  = c0 + n + 3;
            c0 = c0 + n + 2;
        end
        while (cyc < last_vld + 2) begin
            tick();
            mon_en    = (cyc < last_eval);
            fault_clr = clr_last && (cyc == last_vld);
        end
        mon_en    = 1'b0;
        fault_clr = 1'b0;
    endtask

    task automatic set_rand_waves();
        for (int ch = 0; ch < NCH; ch++) begin
            per_a[ch]   = $urandom_range(3, 16);
            ph_a[ch]    = $urandom_range(0, 15);
            stuck_a[ch] = ($urandom_range(0, 5) == 0);
        end
    endtask

    initial begin
        int c0;
        for (int ch = 0; ch < NCH; ch++) begin
            per_a[ch] = 8; ph_a[ch] = 0; stuck_a[ch] = 1'b0;
        end
        // Reset with random inputs
        for (int i = 0; i < 5; i++) begin
            mon_en    = 1'($urandom);
            win_len   = WIN_W'($urandom);
            exp_cnt   = CNT_W'($urandom);
            tol       = CNT_W'($urandom);
            fault_clr = 1'($urandom);
            tick();
            chk("rst_busy", 64'(busy), 64'(0));
            chk("rst_meas_vld", 64'(meas_vld), 64'(0));
            chk("rst_meas_cnt", 64'(meas_cnt), 64'(0));
            chk("rst_ch_ok", 64'(ch_ok), 64'(0));
        end
        rst_l = 1'b1; mon_en = 1'b0; fault_clr = 1'b0; rand_fdbk = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_busy", 64'(busy), 64'(0));
            chk("idle_meas_cnt", 64'(meas_cnt), 64'(0));
            chk("idle_ch_ok", 64'(ch_ok), 64'(0));
        end

        // Nominal: ch0 period 8 over 80 cycles
        set_rand_waves();
        per_a[0] = 8; stuck_a[0] = 1'b0; stuck_a[2] = 1'b0;
        run_win(80, 10, 1, 1, 1'b0);

        // Stuck channel sets sticky fault, good window keeps it, clear, then clear vs set
        stuck_a[2] = 1'b1;
        run_win(80, 10, 1, 1, 1'b0);
        stuck_a[2] = 1'b0; per_a[2] = 8;
        run_win(80, 10, 1, 1, 1'b0);
        tick(); fault_clr = 1'b1; tick(); fault_clr = 1'b0; tick();
        stuck_a[2] = 1'b1;
        run_win(80, 10, 1, 1, 1'b1);

        // Saturation and one-cycle window
        per_a[1] = 4; stuck_a[1] = 1'b0;
        run_win(16400, 4095, 0, 1, 1'b0);
        run_win(0, 0, 0, 1, 1'b0);

        // Continuous mode
        set_rand_waves();
        run_win(20, 3, 1, 5, 1'b0);

        // Abort during COUNT
        win_len = WIN_W'(50);
        repeat (4) tick();
        mon_en = 1'b1;
        c0 = cyc;
        while (cyc < c0 + 9) tick();
        chk("abort_busy_before", 64'(busy), 64'(1));
        mon_en = 1'b0;
        tick();
        chk("abort_busy_after", 64'(busy), 64'(0));
        repeat (60) tick();
        chk("abort_meas_cnt", 64'(meas_cnt), 64'(last_cnt_m));
        chk("abort_ch_ok", 64'(ch_ok), 64'(last_ok_m));

        // Randomized windows
        for (int it = 0; it < 8; it++) begin
            int wl;
            set_rand_waves();
            wl = $urandom_range(0, 200);
            run_win(wl, wl / per_a[0] + $urandom_range(0, 2), $urandom_range(0, 3),
                    $urandom_range(1, 3), 1'($urandom));
        end

        repeat (5) tick();
        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
